// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   state_t    - controller FSM encoding (RUN / REDIRECT / MEM_WAIT)
//   ctrl_t     - bundle of the five pipeline control strobes
//   CTRL_*     - the fixed control patterns used by the priority decoder
//   load_use() - load-use hazard detect between the ID and EX stages
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic idex_flush;
    logic pipe_hold;
  } ctrl_t;

  // Held in reset: nothing advances, both front-end registers are scrubbed.
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b1,
                                    idex_flush: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b0,
                                    idex_flush: 1'b0, pipe_hold: 1'b0};
  // Whole pipe frozen while the data memory is busy.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                    idex_flush: 1'b0, pipe_hold: 1'b1};
  // Taken redirect: load the target and squash both younger instructions.
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b1,
                                    idex_flush: 1'b1, pipe_hold: 1'b0};
  // Load-use: hold PC and IF/ID, send a bubble into EX.
  localparam ctrl_t CTRL_LDUSE  = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                    idex_flush: 1'b1, pipe_hold: 1'b0};
  // Fetch not ready: hold PC and write a bubble into ID.
  localparam ctrl_t CTRL_IWAIT  = '{pc_write: 1'b0, ifid_write: 1'b1, if_flush: 1'b1,
                                    idex_flush: 1'b0, pipe_hold: 1'b0};

  // x0 is never a real producer, so a load targeting it cannot cause a hazard.
  function automatic logic load_use(input logic [4:0] id_rs1, input logic [4:0] id_rs2,
                                    input logic use_rs1, input logic use_rs2,
                                    input logic [4:0] ex_rd, input logic ex_mem_read);
    logic hit_s;
    hit_s = (use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd));
    return ex_mem_read && (ex_rd != 5'd0) && hit_s;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Free-running event counter, wraps modulo 2^W.
//   clk   - clock
//   rst   - asynchronous active-high reset, clears the count
//   en_i  - count this cycle
//   cnt_o - current count
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment when enabled, natural wrap at all-ones.
  always_comb begin
    if (en_i) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Resolves data-memory wait,
// EX-stage redirects, load-use hazards and fetch wait, in that priority.
// Control outputs are combinational from the FSM state and current inputs.
//   clk, rst                     - clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2  - ID-stage source operands and their use flags
//   ex_rd, ex_mem_read           - EX-stage destination and load flag
//   ex_branch_taken              - redirect resolved in EX
//   imem_stall, dmem_stall       - fetch not valid / data memory busy
//   pc_write, ifid_write, if_flush, idex_flush, pipe_hold - pipeline controls
//   stall_cnt, flush_cnt         - performance counters
//   state                        - FSM state for debug
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  // The redirect cycle itself is the first flushed slot; REDIRECT covers the rest.
  localparam logic [2:0] RELOAD = 3'(BR_PENALTY - 32'd1);
  localparam bit         MULTI  = (BR_PENALTY > 32'd1);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [2:0] rcnt_q, rcnt_d;
  state_t     eff_s;
  logic       lu_s;
  ctrl_t      ctrl_s;

  assign lu_s = load_use(id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read);

  // Once dmem releases, MEM_WAIT behaves exactly like the state it interrupted.
  assign eff_s = (state_q == MEM_WAIT) ? ret_q : state_q;

  // State register: FSM state, saved return state and redirect slot count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      rcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic, following the same priority as the outputs.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rcnt_d  = rcnt_q;
    if (dmem_stall) begin
      // rcnt stays frozen; remember where to resume.
      state_d = MEM_WAIT;
      if (eff_s == REDIRECT) begin
        ret_d = REDIRECT;
      end else begin
        ret_d = RUN;
      end
    end else begin
      ret_d = RUN;
      case (eff_s)
        RUN: begin
          if (ex_branch_taken && MULTI) begin
            state_d = REDIRECT;
            rcnt_d  = RELOAD;
          end else begin
            state_d = RUN;
          end
        end
        REDIRECT: begin
          if (ex_branch_taken) begin
            state_d = REDIRECT;
            rcnt_d  = RELOAD;
          end else if (imem_stall) begin
            state_d = REDIRECT;
          end else if (rcnt_q <= 3'd1) begin
            state_d = RUN;
            rcnt_d  = 3'd0;
          end else begin
            state_d = REDIRECT;
            rcnt_d  = rcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          rcnt_d  = 3'd0;
        end
      endcase
    end
  end

  // Output decode: reset, then dmem > redirect > load-use > fetch wait > normal.
  always_comb begin
    ctrl_s = CTRL_NORMAL;
    if (rst) begin
      ctrl_s = CTRL_RESET;
    end else if (dmem_stall) begin
      ctrl_s = CTRL_FREEZE;
    end else begin
      case (eff_s)
        RUN: begin
          if (ex_branch_taken) begin
            ctrl_s = CTRL_BRANCH;
          end else if (lu_s) begin
            ctrl_s = CTRL_LDUSE;
          end else if (imem_stall) begin
            ctrl_s = CTRL_IWAIT;
          end else begin
            ctrl_s = CTRL_NORMAL;
          end
        end
        REDIRECT: begin
          // ID holds a flushed slot, so load-use is irrelevant here.
          ctrl_s.ifid_write = 1'b1;
          ctrl_s.if_flush   = 1'b1;
          ctrl_s.pipe_hold  = 1'b0;
          if (ex_branch_taken) begin
            ctrl_s.pc_write   = 1'b1;
            ctrl_s.idex_flush = 1'b1;
          end else begin
            ctrl_s.pc_write   = !imem_stall;
            ctrl_s.idex_flush = 1'b0;
          end
        end
        default: begin
          ctrl_s = CTRL_FREEZE;
        end
      endcase
    end
  end

  assign pc_write   = ctrl_s.pc_write;
  assign ifid_write = ctrl_s.ifid_write;
  assign if_flush   = ctrl_s.if_flush;
  assign idex_flush = ctrl_s.idex_flush;
  assign pipe_hold  = ctrl_s.pipe_hold;
  assign state      = state_q;

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (!rst && !ctrl_s.pc_write),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (!rst && ctrl_s.if_flush),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scoreboard bench for pipe_hazard_ctrl with BR_PENALTY=2. Each cycle pushes
// the expected control bundle, state and counter values, then pops and
// compares them shortly after the inputs settle (away from posedge).
// Control bundle order: {pc_write, ifid_write, if_flush, idex_flush, pipe_hold}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_RDR = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;

  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_FRZ  = 5'b00001;
  localparam logic [4:0] C_BR   = 5'b11110;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_IM   = 5'b01100;
  localparam logic [4:0] C_RDR  = 5'b11100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        ex_branch_taken, imem_stall, dmem_stall;
  logic        pc_write, ifid_write, if_flush, idex_flush, pipe_hold;
  logic [63:0] stall_cnt, flush_cnt;
  logic [1:0]  state;

  typedef struct {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [63:0] sc;
    logic [63:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_sc   = 64'd0;
  logic [63:0] exp_fc   = 64'd0;

  pipe_hazard_ctrl #(.BR_PENALTY(2), .CNT_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .imem_stall      (imem_stall),
    .dmem_stall      (dmem_stall),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .if_flush        (if_flush),
    .idex_flush      (idex_flush),
    .pipe_hold       (pipe_hold),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctl_now();
    return {pc_write, ifid_write, if_flush, idex_flush, pipe_hold};
  endfunction

  // One cycle: drive at negedge, push expectation, pop and compare 2ns later.
  task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                     input logic br, input logic im, input logic dm,
                     input logic [4:0] ectl, input logic [1:0] est);
    exp_t e;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr;
    ex_branch_taken = br; imem_stall = im; dmem_stall = dm;
    e.ctl = ectl; e.st = est; e.sc = exp_sc; e.fc = exp_fc;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    check_val({tag, ".ctl"},   64'(ctl_now()), 64'(e.ctl));
    check_val({tag, ".state"}, 64'(state),     64'(e.st));
    check_val({tag, ".stall"}, stall_cnt,      e.sc);
    check_val({tag, ".flush"}, flush_cnt,      e.fc);
    if (!e.ctl[4]) exp_sc++;
    if (e.ctl[2])  exp_fc++;
  endtask

  // Cycle with no hazard operands present.
  task automatic ctl_cyc(input string tag, input logic br, input logic im, input logic dm,
                         input logic [4:0] ectl, input logic [1:0] est);
    cyc(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, im, dm, ectl, est);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, ".ctl"},   64'(ctl_now()), 64'(C_RST));
    check_val({tag, ".state"}, 64'(state),     64'(S_RUN));
    check_val({tag, ".stall"}, stall_cnt,      64'd0);
    check_val({tag, ".flush"}, flush_cnt,      64'd0);
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    #2;
    check_reset("rst0");
    @(posedge clk);
    #1;
    check_reset("rst1");
    @(negedge clk);
    rst = 1'b0;

    ctl_cyc("norm", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID; then the load has moved on.
    cyc("lu.rs1",  5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   S_RUN);
    cyc("lu.next", 5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);
    cyc("lu.x0",   5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);
    cyc("lu.rs2",  5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   S_RUN);
    cyc("lu.nouse",5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Fetch wait in RUN.
    ctl_cyc("im", 1'b0, 1'b1, 1'b0, C_IM, S_RUN);

    // Single taken redirect: two flushed slots.
    ctl_cyc("br.0", 1'b1, 1'b0, 1'b0, C_BR,   S_RUN);
    ctl_cyc("br.1", 1'b0, 1'b0, 1'b0, C_RDR,  S_RDR);
    ctl_cyc("br.2", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Redirect followed by three fetch-wait cycles in REDIRECT.
    ctl_cyc("bri.0", 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    for (int i = 0; i < 3; i++) begin
      ctl_cyc("bri.w", 1'b0, 1'b1, 1'b0, C_IM, S_RDR);
    end
    ctl_cyc("bri.4", 1'b0, 1'b0, 1'b0, C_RDR,  S_RDR);
    ctl_cyc("bri.5", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // dmem wait for 5 cycles with the redirect held; acted on in cycle 6.
    ctl_cyc("dm.0", 1'b1, 1'b0, 1'b1, C_FRZ, S_RUN);
    for (int i = 0; i < 4; i++) begin
      ctl_cyc("dm.w", 1'b1, 1'b0, 1'b1, C_FRZ, S_MW);
    end
    ctl_cyc("dm.br",  1'b1, 1'b0, 1'b0, C_BR,   S_MW);
    ctl_cyc("dm.rdr", 1'b0, 1'b0, 1'b0, C_RDR,  S_RDR);
    ctl_cyc("dm.end", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Redirect and load-use together; load-use still present in REDIRECT.
    cyc("lubr.0", 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   S_RUN);
    cyc("lubr.1", 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_RDR,  S_RDR);
    ctl_cyc("lubr.2", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Second redirect while in REDIRECT reloads the slot count.
    ctl_cyc("rl.0", 1'b1, 1'b0, 1'b0, C_BR,   S_RUN);
    ctl_cyc("rl.1", 1'b1, 1'b0, 1'b0, C_BR,   S_RDR);
    ctl_cyc("rl.2", 1'b0, 1'b0, 1'b0, C_RDR,  S_RDR);
    ctl_cyc("rl.3", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // dmem wait interrupting REDIRECT resumes the remaining flush slot.
    ctl_cyc("mr.0", 1'b1, 1'b0, 1'b0, C_BR,   S_RUN);
    ctl_cyc("mr.1", 1'b0, 1'b0, 1'b1, C_FRZ,  S_RDR);
    ctl_cyc("mr.2", 1'b0, 1'b0, 1'b0, C_RDR,  S_MW);
    ctl_cyc("mr.3", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    // Reset pulse in the middle of REDIRECT.
    ctl_cyc("rr.0", 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    @(negedge clk);
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rr.async");
    exp_sc = 64'd0;
    exp_fc = 64'd0;
    @(posedge clk);
    #1;
    check_reset("rr.hold");
    @(negedge clk);
    rst = 1'b0;
    ctl_cyc("rr.1", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);
    ctl_cyc("rr.2", 1'b0, 1'b1, 1'b0, C_IM,   S_RUN);
    ctl_cyc("rr.3", 1'b0, 1'b0, 1'b0, C_NORM, S_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
